// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the register file write port between the WB stage and a queued
// multi-cycle result stream, with a forced one-cycle stall against starvation.
module regfile_wport_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        stall_o,
  output logic [31:0] busy_mask,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  // Valid/ready: an mc result transfers on a cycle where mc_valid && mc_ready;
  // mc_ready depends only on registered occupancy. WB has no backpressure.

  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve;

  logic full;
  logic empty;
  logic accept;
  logic push;
  logic pop;
  logic wb_write;
  logic head_denied;
  logic stall_n;
  logic [SW-1:0] starve_n;
  logic fifo_fault;
  logic viol;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign mc_ready = !full;
  assign accept   = mc_valid && mc_ready;
  // x0 results are accepted from the source but never occupy a slot.
  assign push     = accept && (mc_rd != 5'd0);

  // WB wins whenever it carries a real write, even in a stall cycle (that
  // case is a protocol error and the head simply keeps waiting).
  assign wb_write    = wb_valid && (wb_rd != 5'd0);
  assign pop         = !empty && !wb_write;
  assign head_denied = !empty && !pop;

  always_comb begin
    starve_n = starve;
    stall_n  = 1'b0;
    if (empty || pop) begin
      starve_n = '0;
    end else if (starve == STARVE_LAST) begin
      stall_n  = 1'b1;
    end else begin
      starve_n = starve + SW'(1);
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) busy_mask[rd_q[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // Slot-level consistency: a push onto an occupied slot or a pop of an
  // empty slot means the occupancy count and the slots disagree.
  assign fifo_fault = (push && valid_q[wptr]) || (pop && !valid_q[rptr]);

  assign viol = (wb_valid && stall_o)
              || (wb_write && busy_mask[wb_rd])
              || fifo_fault;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]   <= mc_rd;
      data_q[wptr] <= mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        valid_q[wptr] <= 1'b1;
        wptr          <= wptr + AW'(1);
      end
      if (pop) begin
        valid_q[rptr] <= 1'b0;
        rptr          <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      stall_o  <= 1'b0;
      starve   <= '0;
      err      <= 1'b0;
    end else begin
      rf_we <= wb_write || pop;
      if (wb_write) begin
        rf_rd    <= wb_rd;
        rf_wdata <= wb_data;
      end else if (pop) begin
        rf_rd    <= rd_q[rptr];
        rf_wdata <= data_q[rptr];
      end
      stall_o <= stall_n && head_denied;
      starve  <= starve_n;
      err     <= err || viol;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: priority, starvation stall,
// full FIFO ordering, x0 handling, error flag and reset.
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        stall_o;
  logic [31:0] busy_mask;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  regfile_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_ready  (mc_ready),
    .mc_rd     (mc_rd),
    .mc_data   (mc_data),
    .stall_o   (stall_o),
    .busy_mask (busy_mask),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    mc_valid = 1'b0; mc_rd = 5'd0; mc_data = 32'h0;
  endtask

  task automatic drive_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic drive_mc(input logic [4:0] rd, input logic [31:0] d);
    mc_valid = 1'b1; mc_rd = rd; mc_data = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_ready", 32'(mc_ready), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    do_reset();
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);

    // WB priority over a same-cycle multi-cycle result
    drive_wb(5'd5, 32'hAAAA0001);
    drive_mc(5'd7, 32'h12345678);
    tick();
    idle();
    chk("prio_we", 32'(rf_we), 32'd1);
    chk("prio_rd", 32'(rf_rd), 32'd5);
    chk("prio_data", rf_wdata, 32'hAAAA0001);
    chk("prio_busy", busy_mask, 32'h0000_0080);
    tick();
    chk("prio_mc_we", 32'(rf_we), 32'd1);
    chk("prio_mc_rd", 32'(rf_rd), 32'd7);
    chk("prio_mc_data", rf_wdata, 32'h12345678);
    chk("prio_busy_clr", busy_mask, 32'd0);
    tick();
    chk("prio_idle_we", 32'(rf_we), 32'd0);

    // Starvation: head denied four times, then a forced stall
    drive_mc(5'd9, 32'h0000_0099);
    tick();
    idle();
    drive_wb(5'd3, 32'h0000_0033);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("starve_stall", 32'(stall_o), (i == 3) ? 32'd1 : 32'd0);
      chk("starve_wb_rd", 32'(rf_rd), 32'd3);
    end
    idle();
    tick();
    chk("starve_drain_we", 32'(rf_we), 32'd1);
    chk("starve_drain_rd", 32'(rf_rd), 32'd9);
    chk("starve_drain_data", rf_wdata, 32'h0000_0099);
    chk("starve_stall_off", 32'(stall_o), 32'd0);
    chk("starve_err", 32'(err), 32'd0);
    chk("starve_busy", busy_mask, 32'd0);

    // Full FIFO: rd=4 held until a slot frees; port order 1, 2, 4
    drive_wb(5'd10, 32'h0000_000A);
    drive_mc(5'd1, 32'h0000_0011);
    tick();
    drive_mc(5'd2, 32'h0000_0022);
    tick();
    chk("full_ready", 32'(mc_ready), 32'd0);
    chk("full_busy", busy_mask, 32'h0000_0006);
    drive_mc(5'd4, 32'h0000_0044);
    tick();
    chk("full_hold_ready", 32'(mc_ready), 32'd0);
    chk("full_hold_busy", busy_mask, 32'h0000_0006);
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    tick();
    chk("full_w1_rd", 32'(rf_rd), 32'd1);
    chk("full_w1_data", rf_wdata, 32'h0000_0011);
    chk("full_ready_again", 32'(mc_ready), 32'd1);
    tick();
    idle();
    chk("full_w2_rd", 32'(rf_rd), 32'd2);
    chk("full_w2_data", rf_wdata, 32'h0000_0022);
    chk("full_busy4", busy_mask, 32'h0000_0010);
    tick();
    chk("full_w3_we", 32'(rf_we), 32'd1);
    chk("full_w3_rd", 32'(rf_rd), 32'd4);
    chk("full_w3_data", rf_wdata, 32'h0000_0044);
    chk("full_busy_clr", busy_mask, 32'd0);
    tick();
    chk("full_idle_we", 32'(rf_we), 32'd0);

    // x0: WB rd=0 lets the head through; mc rd=0 is dropped
    drive_mc(5'd12, 32'h0000_000C);
    tick();
    drive_wb(5'd0, 32'h0000_DEAD);
    drive_mc(5'd0, 32'h0000_BEEF);
    tick();
    idle();
    chk("x0_head_we", 32'(rf_we), 32'd1);
    chk("x0_head_rd", 32'(rf_rd), 32'd12);
    chk("x0_head_data", rf_wdata, 32'h0000_000C);
    chk("x0_busy", busy_mask, 32'd0);
    tick();
    chk("x0_no_we", 32'(rf_we), 32'd0);
    chk("x0_err", 32'(err), 32'd0);

    // Violation: WB held through the forced stall
    do_reset();
    drive_mc(5'd9, 32'h0000_0099);
    tick();
    idle();
    drive_wb(5'd3, 32'h0000_0033);
    tick(); tick(); tick(); tick();
    chk("viol_stall", 32'(stall_o), 32'd1);
    tick();
    chk("viol_err", 32'(err), 32'd1);
    chk("viol_stall_again", 32'(stall_o), 32'd1);
    chk("viol_wb_rd", 32'(rf_rd), 32'd3);
    idle();
    tick();
    chk("viol_drain_rd", 32'(rf_rd), 32'd9);
    chk("viol_stall_off", 32'(stall_o), 32'd0);
    tick();
    chk("viol_err_sticky", 32'(err), 32'd1);

    // Violation: WB writes a register with a queued result
    do_reset();
    drive_mc(5'd7, 32'h0000_0777);
    tick();
    idle();
    drive_wb(5'd7, 32'h0000_0070);
    tick();
    idle();
    chk("waw_err", 32'(err), 32'd1);
    chk("waw_rd", 32'(rf_rd), 32'd7);
    chk("waw_data", rf_wdata, 32'h0000_0070);
    tick();
    chk("waw_mc_data", rf_wdata, 32'h0000_0777);

    // Reset mid-operation drops a queued entry
    do_reset();
    drive_mc(5'd21, 32'h0000_0015);
    tick();
    chk("mid_busy", busy_mask, 32'h0020_0000);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_busy", busy_mask, 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    tick();
    chk("mid_after_we", 32'(rf_we), 32'd0);
    chk("mid_after_ready", 32'(mc_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
